pipe_hazard_ctrl: RTL

- Parametrised hazard controller for the 5-stage pipelined CPU: forwarding, load-use interlock, taken-branch flush and flag forwarding in one block.
- Keeps a shadow pipeline (EX, MEM, WB) of destination/control metadata for in-flight instructions.
- Generates per-operand forward selects plus stall and flush, replacing hard-wired 3-operand forwarding with an N-operand, interlocked version.
- Sits beside the RF stage; its outputs drive the forward muxes, the PC/IF-RF hold enables and the IF-RF squash.

---
 rtl/pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : hazard control for the 5-stage pipeline: operand forwarding, load-use
//           interlock, taken-branch flush and NZCV flag forwarding.
// Latency : all hazard outputs combinational from shadow state + RF inputs; shadow
//           state and counters update on the next rising edge.
// Backpres: stall holds PC and IF-RF and injects a bubble into EX; flush squashes IF.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   id_*                  RF-stage instruction metadata (valid, rd, controls)
//   id_src_addr/used      NUM_SRC packed source addresses, operand i at [i*REG_W +: REG_W]
//   br_taken              branch resolved taken in RF
//   fwd_sel               per-operand 2-bit select at [2*i +: 2]: 2=EX, 1=MEM, 0=regfile
//   flag_fwd              use live ALU flags instead of latched flags
//   stall, flush          pipeline hold / IF squash
//   ex/mem/wb_valid       shadow-stage valid bits
//   stall_cnt, flush_cnt  saturating event counters
module pipe_hazard_ctrl #(
   parameter int REG_W         = 5,
   parameter int ZERO_REG      = 31,
   parameter int NUM_SRC       = 3,
   parameter int CNT_W         = 16,
   parameter bit BR_DELAY_SLOT = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     id_valid,
   input  logic [REG_W-1:0]         id_rd,
   input  logic                     id_reg_write,
   input  logic                     id_mem_read,
   input  logic                     id_flag_set,
   input  logic                     id_uses_flags,
   input  logic [NUM_SRC*REG_W-1:0] id_src_addr,
   input  logic [NUM_SRC-1:0]       id_src_used,
   input  logic                     br_taken,
   output logic [2*NUM_SRC-1:0]     fwd_sel,
   output logic                     flag_fwd,
   output logic                     stall,
   output logic                     flush,
   output logic                     ex_valid,
   output logic                     mem_valid,
   output logic                     wb_valid,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt
);

   localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

   // EX shadow stage: full metadata
   logic             ex_valid_q,     ex_valid_d;
   logic [REG_W-1:0] ex_rd_q,        ex_rd_d;
   logic             ex_reg_write_q, ex_reg_write_d;
   logic             ex_mem_read_q,  ex_mem_read_d;
   logic             ex_flag_set_q,  ex_flag_set_d;

   // MEM shadow stage: only what MEM forwarding needs. A load here forwards
   // like any other writer, so its mem_read bit is not kept.
   logic             mem_valid_q,     mem_valid_d;
   logic [REG_W-1:0] mem_rd_q,        mem_rd_d;
   logic             mem_reg_write_q, mem_reg_write_d;

   // WB shadow stage: the regfile writes before it reads, so WB is never a
   // forwarding source and only its occupancy is tracked.
   logic             wb_valid_q, wb_valid_d;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [2*NUM_SRC-1:0] fwd_sel_c;
   logic                 load_use_c;
   logic                 stall_c;
   logic                 flush_c;
   logic                 flag_fwd_c;

   // A stage writes register r only if it is live, writes the RF, and r is not XZR.
   function automatic logic stage_writes(input logic             v,
                                         input logic             rw,
                                         input logic [REG_W-1:0] rd,
                                         input logic [REG_W-1:0] r);
      return v && rw && (rd == r) && (r != ZR);
   endfunction

   // ------------------------------------------------------------------
   // Forwarding selects and load-use detection
   // ------------------------------------------------------------------
   always_comb begin
      logic [REG_W-1:0] src;
      logic             ex_hit;
      logic             mem_hit;
      fwd_sel_c  = '0;
      load_use_c = 1'b0;
      src        = '0;
      ex_hit     = 1'b0;
      mem_hit    = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src     = id_src_addr[i*REG_W +: REG_W];
         ex_hit  = stage_writes(ex_valid_q,  ex_reg_write_q,  ex_rd_q,  src);
         mem_hit = stage_writes(mem_valid_q, mem_reg_write_q, mem_rd_q, src);
         if (id_src_used[i] && (src != ZR)) begin
            // A load in EX has no data yet: it never selects EX, and an older
            // writer in MEM may still be forwarded while the interlock holds.
            if (ex_hit && !ex_mem_read_q) begin
               fwd_sel_c[2*i +: 2] = 2'd2;
            end else if (mem_hit) begin
               fwd_sel_c[2*i +: 2] = 2'd1;
            end
            if (ex_hit && ex_mem_read_q) begin
               load_use_c = 1'b1;
            end
         end
      end
   end

   assign stall_c    = id_valid && load_use_c;
   // Stall wins over a taken branch: the branch stays in RF and is re-evaluated
   // once the interlock releases.
   assign flush_c    = id_valid && br_taken && !stall_c && !BR_DELAY_SLOT;
   assign flag_fwd_c = id_uses_flags && ex_valid_q && ex_flag_set_q;

   // ------------------------------------------------------------------
   // Shadow pipeline next state
   // ------------------------------------------------------------------
   always_comb begin
      // Default: bubble into EX
      ex_valid_d     = 1'b0;
      ex_rd_d        = '0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_flag_set_d  = 1'b0;
      if (id_valid && !stall_c) begin
         ex_valid_d     = 1'b1;
         ex_rd_d        = id_rd;
         ex_reg_write_d = id_reg_write;
         ex_mem_read_d  = id_mem_read;
         ex_flag_set_d  = id_flag_set;
      end

      mem_valid_d     = ex_valid_q;
      mem_rd_d        = ex_rd_q;
      mem_reg_write_d = ex_reg_write_q;

      wb_valid_d      = mem_valid_q;

      // Saturating counters: hold at all-ones
      stall_cnt_d = stall_cnt_q;
      if (stall_c && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      flush_cnt_d = flush_cnt_q;
      if (flush_c && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_q      <= 1'b0;
         ex_rd_q         <= '0;
         ex_reg_write_q  <= 1'b0;
         ex_mem_read_q   <= 1'b0;
         ex_flag_set_q   <= 1'b0;
         mem_valid_q     <= 1'b0;
         mem_rd_q        <= '0;
         mem_reg_write_q <= 1'b0;
         wb_valid_q      <= 1'b0;
         stall_cnt_q     <= '0;
         flush_cnt_q     <= '0;
      end else begin
         ex_valid_q      <= ex_valid_d;
         ex_rd_q         <= ex_rd_d;
         ex_reg_write_q  <= ex_reg_write_d;
         ex_mem_read_q   <= ex_mem_read_d;
         ex_flag_set_q   <= ex_flag_set_d;
         mem_valid_q     <= mem_valid_d;
         mem_rd_q        <= mem_rd_d;
         mem_reg_write_q <= mem_reg_write_d;
         wb_valid_q      <= wb_valid_d;
         stall_cnt_q     <= stall_cnt_d;
         flush_cnt_q     <= flush_cnt_d;
      end
   end

   assign fwd_sel   = fwd_sel_c;
   assign flag_fwd  = flag_fwd_c;
   assign stall     = stall_c;
   assign flush     = flush_c;
   assign ex_valid  = ex_valid_q;
   assign mem_valid = mem_valid_q;
   assign wb_valid  = wb_valid_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
